multi_material_system: RTL and testbench

MULTI_MATERIAL_SYSTEM -- requirements
Module: multi_material_system

---
 rtl/material_pkg.sv | 18 +
 rtl/multi_material_system_if.sv | 34 +++
 rtl/sample_averager.sv | 52 +++++
 rtl/multi_material_system.sv | 175 +++++++++++++++++
 tb/tb_multi_material_system.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/material_pkg.sv
// Shared types and constants for the pick-and-place temperature checker.
// Holds the controller state encoding and the XADC code scale.
package material_pkg;

    // XADC codes per degree Celsius
    localparam int unsigned LSB_PER_C = 68;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        COMPARE,
        PICKUP,
        REJECT,
        FAULT
    } state_t;

endpackage

// File: rtl/multi_material_system_if.sv
// Station-side bus of multi_material_system.
// master: trigger, stationSel, windowLo/windowHi, digitalTemp, ready (driven)
//         enable, correct, control, fault, busy, avgTemp (observed)
// slave : the controller, directions reversed.
interface multi_material_system_if #(
    parameter int unsigned NUM_STATIONS = 4,
    parameter int unsigned TEMP_WIDTH   = 12
);
    localparam int unsigned SEL_WIDTH = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;

    logic                               trigger;
    logic [SEL_WIDTH-1:0]               stationSel;
    logic [NUM_STATIONS*TEMP_WIDTH-1:0] windowLo;
    logic [NUM_STATIONS*TEMP_WIDTH-1:0] windowHi;
    logic [TEMP_WIDTH-1:0]              digitalTemp;
    logic                               ready;
    logic                               enable;
    logic                               correct;
    logic                               control;
    logic                               fault;
    logic                               busy;
    logic [TEMP_WIDTH-1:0]              avgTemp;

    modport master (
        output trigger, stationSel, windowLo, windowHi, digitalTemp, ready,
        input  enable, correct, control, fault, busy, avgTemp
    );

    modport slave (
        input  trigger, stationSel, windowLo, windowHi, digitalTemp, ready,
        output enable, correct, control, fault, busy, avgTemp
    );

endinterface

// File: rtl/sample_averager.sv
// Accumulates 2^AVG_LOG2 ready-qualified samples and watches for a stalled XADC.
// Ports: clk/rst, clr (restart), en (sampling window), ready/din (XADC result),
//        acc (running sum), done_c (last sample this clock), timeout_c (stall limit hit).
module sample_averager #(
    parameter int unsigned TEMP_WIDTH     = 12,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic                           ready,
    input  logic [TEMP_WIDTH-1:0]          din,
    output logic [TEMP_WIDTH+AVG_LOG2-1:0] acc,
    output logic                           done_c,
    output logic                           timeout_c
);
    localparam int unsigned AW          = TEMP_WIDTH + AVG_LOG2;
    localparam int unsigned NUM_SAMPLES = 1 << AVG_LOG2;
    localparam int unsigned SCW         = AVG_LOG2 + 1;
    localparam int unsigned TCW         = $clog2(TIMEOUT_CYCLES + 1);

    logic [SCW-1:0] scnt;
    logic [TCW-1:0] tcnt;

    // Sum, sample count and consecutive not-ready count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            scnt <= '0;
            tcnt <= '0;
        end else if (clr) begin
            acc  <= '0;
            scnt <= '0;
            tcnt <= '0;
        end else if (en) begin
            if (ready) begin
                acc  <= acc + AW'(din);
                scnt <= scnt + SCW'(1);
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TCW'(1);
            end
        end
    end

    // Flags fire on the clock that completes the condition
    assign done_c    = en && ready && (scnt == SCW'(NUM_SAMPLES - 1));
    assign timeout_c = en && !ready && (tcnt == TCW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multi_material_system.sv
// Temperature-window check before pickup: settle, average XADC samples,
// compare against the selected station window, then drive the pickup actuator.
// Ports: ACLK, ARESET (async, active high), bus (slave modport):
//   trigger/stationSel start a run, windowLo/windowHi per-station limits,
//   digitalTemp/ready XADC result, enable XADC request, correct/avgTemp result,
//   control actuator, fault timeout/illegal station, busy not idle.
module multi_material_system
    import material_pkg::*;
#(
    parameter int unsigned NUM_STATIONS   = 4,
    parameter int unsigned TEMP_WIDTH     = 12,
    parameter int unsigned SETTLE_CYCLES  = 300,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned PICKUP_CYCLES  = 300,
    parameter int unsigned TIMEOUT_CYCLES = 50
) (
    input logic                    ACLK,
    input logic                    ARESET,
    multi_material_system_if.slave bus
);
    localparam int unsigned TW      = TEMP_WIDTH;
    localparam int unsigned SW      = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;
    localparam int unsigned AW      = TEMP_WIDTH + AVG_LOG2;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > PICKUP_CYCLES) ? SETTLE_CYCLES : PICKUP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   station_q, station_d;
    logic            correct_q, correct_d;
    logic            fault_q, fault_d;
    logic [TW-1:0]   avg_q, avg_d;
    logic            enable_q, control_q, busy_q;
    logic            trig_q;

    logic [AW-1:0]   acc;
    logic            done_c, timeout_c;
    logic            accept_c, illegal_c, in_window_c;
    logic [TW-1:0]   lo_c, hi_c, avg_c;

    sample_averager #(
        .TEMP_WIDTH     (TEMP_WIDTH),
        .AVG_LOG2       (AVG_LOG2),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_avg (
        .clk       (ACLK),
        .rst       (ARESET),
        .clr       (state_q == SETTLE),
        .en        (state_q == SAMPLE),
        .ready     (bus.ready),
        .din       (bus.digitalTemp),
        .acc       (acc),
        .done_c    (done_c),
        .timeout_c (timeout_c)
    );

    // Rising edge against the registered copy, honoured only when idle
    assign accept_c  = (state_q == IDLE) && bus.trigger && !trig_q;
    assign illegal_c = ({1'b0, bus.stationSel} >= (SW + 1)'(NUM_STATIONS));

    // Window of the latched station
    always_comb begin
        lo_c = '0;
        hi_c = '0;
        for (int unsigned i = 0; i < NUM_STATIONS; i++) begin
            if (station_q == SW'(i)) begin
                lo_c = bus.windowLo[i*TW +: TW];
                hi_c = bus.windowHi[i*TW +: TW];
            end
        end
    end

    // Truncating average; an inverted window can never match
    assign avg_c       = TW'(acc >> AVG_LOG2);
    assign in_window_c = (lo_c <= avg_c) && (avg_c <= hi_c);

    // State and output registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            station_q <= '0;
            correct_q <= 1'b0;
            fault_q   <= 1'b0;
            avg_q     <= '0;
            enable_q  <= 1'b0;
            control_q <= 1'b0;
            busy_q    <= 1'b0;
            trig_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            station_q <= station_d;
            correct_q <= correct_d;
            fault_q   <= fault_d;
            avg_q     <= avg_d;
            enable_q  <= (state_d == SAMPLE);
            control_q <= (state_d == PICKUP);
            busy_q    <= (state_d != IDLE);
            trig_q    <= bus.trigger;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        station_d = station_q;
        correct_d = correct_q;
        fault_d   = fault_q;
        avg_d     = avg_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept_c) begin
                    station_d = bus.stationSel;
                    correct_d = 1'b0;
                    fault_d   = 1'b0;
                    state_d   = illegal_c ? FAULT : SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                cnt_d = '0;
                if (done_c) begin
                    state_d = COMPARE;
                end else if (timeout_c) begin
                    state_d = FAULT;
                end
            end
            COMPARE: begin
                cnt_d     = '0;
                avg_d     = avg_c;
                correct_d = in_window_c;
                state_d   = in_window_c ? PICKUP : REJECT;
            end
            PICKUP: begin
                if (cnt_q == CW'(PICKUP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            REJECT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            FAULT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // Entering FAULT flags the run and voids any pass
        if (state_d == FAULT) begin
            fault_d   = 1'b1;
            correct_d = 1'b0;
        end
    end

    assign bus.enable  = enable_q;
    assign bus.correct = correct_q;
    assign bus.control = control_q;
    assign bus.fault   = fault_q;
    assign bus.busy    = busy_q;
    assign bus.avgTemp = avg_q;

endmodule

// File: tb/tb_multi_material_system.sv
// Directed bench for multi_material_system with three stations:
// station 0 full range, station 1 20..30 C, station 2 inverted window.
module tb_multi_material_system;
    import material_pkg::*;

    localparam int unsigned NS = 3;
    localparam int unsigned TW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    multi_material_system_if #(.NUM_STATIONS(NS), .TEMP_WIDTH(TW)) bus ();

    multi_material_system #(
        .NUM_STATIONS   (NS),
        .TEMP_WIDTH     (TW),
        .SETTLE_CYCLES  (300),
        .AVG_LOG2       (2),
        .PICKUP_CYCLES  (300),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] sel);
        bus.stationSel = sel;
        bus.trigger    = 1'b1;
        step();
        bus.trigger    = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (bus.enable !== 1'b0)  begin fails++; $display("FAIL reset_enable: got %b want 0", bus.enable); end
        checks++; if (bus.correct !== 1'b0) begin fails++; $display("FAIL reset_correct: got %b want 0", bus.correct); end
        checks++; if (bus.control !== 1'b0) begin fails++; $display("FAIL reset_control: got %b want 0", bus.control); end
        checks++; if (bus.fault !== 1'b0)   begin fails++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
        checks++; if (bus.busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.avgTemp !== 12'd0) begin fails++; $display("FAIL reset_avg: got %0d want 0", bus.avgTemp); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_pass();
        int n;
        bus.digitalTemp = 12'(25 * LSB_PER_C);
        bus.ready       = 1'b1;
        pulse(2'd1);
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL pass_busy: got %b want 1", bus.busy); end
        n = 0;
        while (bus.enable !== 1'b1 && n < 1000) begin n++; step(); end
        checks++; if (n != 300) begin fails++; $display("FAIL pass_settle_len: got %0d want 300", n); end
        n = 0;
        while (bus.control !== 1'b1 && n < 100) begin n++; step(); end
        checks++; if (n != 5) begin fails++; $display("FAIL pass_sample_compare_len: got %0d want 5", n); end
        checks++; if (bus.avgTemp !== 12'd1700) begin fails++; $display("FAIL pass_avg: got %0d want 1700", bus.avgTemp); end
        checks++; if (bus.correct !== 1'b1) begin fails++; $display("FAIL pass_correct: got %b want 1", bus.correct); end
        n = 0;
        while (bus.control === 1'b1 && n < 1000) begin n++; step(); end
        checks++; if (n != 300) begin fails++; $display("FAIL pass_pickup_len: got %0d want 300", n); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL pass_idle: got %b want 0", bus.busy); end
        checks++; if (bus.correct !== 1'b1) begin fails++; $display("FAIL pass_correct_hold: got %b want 1", bus.correct); end
    endtask

    task automatic test_illegal_station();
        pulse(2'd3);
        checks++; if (bus.fault !== 1'b1)   begin fails++; $display("FAIL illegal_fault: got %b want 1", bus.fault); end
        checks++; if (bus.correct !== 1'b0) begin fails++; $display("FAIL illegal_correct: got %b want 0", bus.correct); end
        checks++; if (bus.enable !== 1'b0)  begin fails++; $display("FAIL illegal_enable: got %b want 0", bus.enable); end
        step();
        checks++; if (bus.busy !== 1'b0)  begin fails++; $display("FAIL illegal_no_settle: busy got %b want 0", bus.busy); end
        checks++; if (bus.fault !== 1'b1) begin fails++; $display("FAIL illegal_fault_hold: got %b want 1", bus.fault); end
    endtask

    task automatic test_reject();
        int n;
        logic seen;
        // Too hot for station 1
        bus.digitalTemp = 12'(40 * LSB_PER_C);
        bus.ready       = 1'b1;
        pulse(2'd1);
        checks++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL reject_fault_clear: got %b want 0", bus.fault); end
        n = 0; seen = 1'b0;
        while (bus.busy === 1'b1 && n < 2000) begin
            if (bus.control === 1'b1) seen = 1'b1;
            n++; step();
        end
        checks++; if (n != 306) begin fails++; $display("FAIL reject_run_len: got %0d want 306", n); end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL reject_control: got %b want 0", seen); end
        checks++; if (bus.correct !== 1'b0) begin fails++; $display("FAIL reject_correct: got %b want 0", bus.correct); end
        checks++; if (bus.avgTemp !== 12'd2720) begin fails++; $display("FAIL reject_avg: got %0d want 2720", bus.avgTemp); end
        // Station 2 window is inverted (lo 3000 > hi 1000)
        bus.digitalTemp = 12'd2000;
        pulse(2'd2);
        n = 0; seen = 1'b0;
        while (bus.busy === 1'b1 && n < 2000) begin
            if (bus.control === 1'b1) seen = 1'b1;
            n++; step();
        end
        checks++; if (n != 306) begin fails++; $display("FAIL inverted_run_len: got %0d want 306", n); end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL inverted_control: got %b want 0", seen); end
        checks++; if (bus.correct !== 1'b0) begin fails++; $display("FAIL inverted_correct: got %b want 0", bus.correct); end
        checks++; if (bus.avgTemp !== 12'd2000) begin fails++; $display("FAIL inverted_avg: got %0d want 2000", bus.avgTemp); end
    endtask

    task automatic test_boundary();
        int n;
        logic [TW-1:0] s [4];
        s[0] = 12'd2040; s[1] = 12'd2040; s[2] = 12'd2040; s[3] = 12'd2043;
        bus.ready = 1'b0;
        pulse(2'd1);
        n = 0;
        while (bus.enable !== 1'b1 && n < 1000) begin n++; step(); end
        checks++; if (n != 300) begin fails++; $display("FAIL boundary_settle_len: got %0d want 300", n); end
        // Samples separated by not-ready clocks carrying junk
        for (int i = 0; i < 4; i++) begin
            bus.digitalTemp = s[i];
            bus.ready       = 1'b1;
            step();
            bus.ready       = 1'b0;
            bus.digitalTemp = 12'd4095;
            step();
        end
        checks++; if (bus.control !== 1'b1) begin fails++; $display("FAIL boundary_control: got %b want 1", bus.control); end
        checks++; if (bus.avgTemp !== 12'd2040) begin fails++; $display("FAIL boundary_avg: got %0d want 2040", bus.avgTemp); end
        checks++; if (bus.correct !== 1'b1) begin fails++; $display("FAIL boundary_correct: got %b want 1", bus.correct); end
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin n++; step(); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL boundary_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_timeout();
        int n;
        bus.ready = 1'b0;
        pulse(2'd0);
        n = 0;
        while (bus.enable !== 1'b1 && n < 1000) begin n++; step(); end
        checks++; if (bus.enable !== 1'b1) begin fails++; $display("FAIL timeout_enable: got %b want 1", bus.enable); end
        n = 0;
        while (bus.enable === 1'b1 && n < 200) begin n++; step(); end
        checks++; if (n != 50) begin fails++; $display("FAIL timeout_len: got %0d want 50", n); end
        checks++; if (bus.fault !== 1'b1)   begin fails++; $display("FAIL timeout_fault: got %b want 1", bus.fault); end
        checks++; if (bus.correct !== 1'b0) begin fails++; $display("FAIL timeout_correct: got %b want 0", bus.correct); end
        checks++; if (bus.busy !== 1'b1)    begin fails++; $display("FAIL timeout_busy_fault: got %b want 1", bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0)  begin fails++; $display("FAIL timeout_idle: got %b want 0", bus.busy); end
        checks++; if (bus.fault !== 1'b1) begin fails++; $display("FAIL timeout_fault_hold: got %b want 1", bus.fault); end
    endtask

    task automatic test_trigger_during_pickup();
        int n;
        logic seen;
        bus.digitalTemp = 12'd1700;
        bus.ready       = 1'b1;
        pulse(2'd1);
        checks++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL pickup_fault_clear: got %b want 0", bus.fault); end
        n = 0;
        while (bus.control !== 1'b1 && n < 1000) begin n++; step(); end
        n = 0;
        while (bus.control === 1'b1 && n < 1000) begin
            if (n == 50) begin bus.stationSel = 2'd0; bus.trigger = 1'b1; end
            if (n == 52) bus.trigger = 1'b0;
            n++; step();
        end
        checks++; if (n != 300) begin fails++; $display("FAIL pickup_len_with_edge: got %0d want 300", n); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL pickup_edge_ignored: busy seen %b want 0", seen); end
    endtask

    task automatic test_reset_mid_pickup();
        int n;
        logic seen;
        bus.digitalTemp = 12'd1700;
        bus.ready       = 1'b1;
        pulse(2'd1);
        n = 0;
        while (bus.control !== 1'b1 && n < 1000) begin n++; step(); end
        for (int i = 0; i < 20; i++) step();
        checks++; if (bus.control !== 1'b1) begin fails++; $display("FAIL midreset_pre_control: got %b want 1", bus.control); end
        // Reset between edges with trigger rising at the same moment
        #1;
        bus.trigger = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (bus.control !== 1'b0) begin fails++; $display("FAIL midreset_control: got %b want 0", bus.control); end
        checks++; if (bus.busy !== 1'b0)    begin fails++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.correct !== 1'b0) begin fails++; $display("FAIL midreset_correct: got %b want 0", bus.correct); end
        checks++; if (bus.avgTemp !== 12'd0) begin fails++; $display("FAIL midreset_avg: got %0d want 0", bus.avgTemp); end
        step();
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.busy !== 1'b0 || bus.control !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL midreset_no_restart: activity %b want 0", seen); end
        bus.trigger = 1'b0;
        step();
    endtask

    initial begin
        bus.trigger     = 1'b0;
        bus.stationSel  = 2'd0;
        bus.windowLo    = {12'd3000, 12'(20 * LSB_PER_C), 12'd0};
        bus.windowHi    = {12'd1000, 12'(30 * LSB_PER_C), 12'd4095};
        bus.digitalTemp = 12'd0;
        bus.ready       = 1'b0;
        test_reset();
        test_pass();
        test_illegal_station();
        test_reject();
        test_boundary();
        test_timeout();
        test_trigger_during_pickup();
        test_reset_mid_pickup();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
